// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - LED pattern generator (OFF/ON/BLINK/CHASE) stepped by a prescaled tick
module led_pattern_ctrl #(
    parameter int DIV   = 25000000,
    parameter int N_LED = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [N_LED-1:0] led,
    output logic             tick
);

    localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_CHASE = 2'b11
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             tick_q, tick_d;
    logic [N_LED-1:0] led_entry;
    logic [N_LED-1:0] led_step;

    always_comb begin
        led_entry = '0;
        case (mode_e'(mode))
            MODE_ON:    led_entry = '1;
            MODE_CHASE: led_entry = dir ? {1'b1, {(N_LED-1){1'b0}}}
                                        : {{(N_LED-1){1'b0}}, 1'b1};
            default:    led_entry = '0;
        endcase
    end

    // OFF and ON keep their entry pattern; only BLINK and CHASE evolve per step
    always_comb begin
        led_step = led_q;
        case (mode_q)
            MODE_BLINK: led_step = ~led_q;
            MODE_CHASE: led_step = dir ? {led_q[0], led_q[N_LED-1:1]}
                                       : {led_q[N_LED-2:0], led_q[N_LED-1]};
            default:    led_step = led_q;
        endcase
    end

    // A mode change wins over a coincident wrap and discards that step
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        led_d  = led_q;
        tick_d = 1'b0;
        if (mode_e'(mode) != mode_q) begin
            mode_d = mode_e'(mode);
            cnt_d  = '0;
            led_d  = led_entry;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                led_d  = led_step;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_OFF;
            cnt_q  <= '0;
            led_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule
